// File: rtl/coin_pulse_conditioner.sv
// Turns a raw, bouncy coin-sensor line into clean single-cycle x pulses.
// Coins that arrive while x is still spaced out are queued in a saturating counter.
module coin_pulse_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int GAP_CYCLES      = 2,
    parameter int PEND_W          = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              coin_raw,
    output logic              x,
    output logic [PEND_W-1:0] pending,
    output logic              busy,
    output logic              overflow
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic [7:0] DB_LIM   = 8'(DEBOUNCE_CYCLES);
    localparam logic [7:0] GAP_LOAD = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;
    localparam logic [PEND_W-1:0] PEND_MAX = '1;
    localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

    logic              s1_q, s1_d;
    logic              s2_q, s2_d;
    logic              db_q, db_d;
    logic [7:0]        db_cnt_q, db_cnt_d;
    state_t            state_q, state_d;
    logic [7:0]        gap_cnt_q, gap_cnt_d;
    logic [PEND_W-1:0] pending_q, pending_d;
    logic              overflow_q, overflow_d;
    logic              x_q, x_d;
    logic              coin_event;
    logic              issue;

    always_comb begin
        s1_d       = coin_raw;
        s2_d       = s1_q;
        db_d       = db_q;
        db_cnt_d   = 8'd0;
        state_d    = state_q;
        gap_cnt_d  = gap_cnt_q;
        pending_d  = pending_q;
        overflow_d = overflow_q;
        issue      = 1'b0;

        // The debounced level flips on the edge where the disagreement run reaches its limit.
        if (s2_q != db_q) begin
            if (db_cnt_q == DB_LIM - 8'd1) begin
                db_d     = ~db_q;
                db_cnt_d = 8'd0;
            end else begin
                db_cnt_d = db_cnt_q + 8'd1;
            end
        end
        coin_event = ~db_q & db_d;

        case (state_q)
            IDLE: begin
                if (pending_q != '0) begin
                    issue   = 1'b1;
                    state_d = PULSE;
                end
            end
            PULSE: begin
                if (GAP_CYCLES > 0) begin
                    state_d   = GAP;
                    gap_cnt_d = GAP_LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            GAP: begin
                if (gap_cnt_q == 8'd0) begin
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // A simultaneous arrival and issue cancel out, so only the lone cases move the count.
        if (coin_event && !issue) begin
            if (pending_q == PEND_MAX) begin
                overflow_d = 1'b1;
            end else begin
                pending_d = pending_q + PEND_ONE;
            end
        end else if (!coin_event && issue) begin
            pending_d = pending_q - PEND_ONE;
        end

        x_d = (state_d == PULSE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            db_q       <= 1'b0;
            db_cnt_q   <= 8'd0;
            state_q    <= IDLE;
            gap_cnt_q  <= 8'd0;
            pending_q  <= '0;
            overflow_q <= 1'b0;
            x_q        <= 1'b0;
        end else begin
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            db_q       <= db_d;
            db_cnt_q   <= db_cnt_d;
            state_q    <= state_d;
            gap_cnt_q  <= gap_cnt_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
            x_q        <= x_d;
        end
    end

    assign x        = x_q;
    assign pending  = pending_q;
    assign overflow = overflow_q;
    assign busy     = (state_q != IDLE) || (pending_q != '0);

endmodule
